// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the PC, drives the
// instruction memory port and presents pc/inst/exception to IF/ID.
// Optional feature: define IF_PERF_CNT_EN to add the perf_fetch_cnt and
// perf_wait_cnt performance counter outputs.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_REQ   | request issued this cycle at pc (or AdEL if pc misaligned)
// S_WAIT  | request at pc outstanding, waiting for inst_ack
// S_HOLD  | word captured while stalled, presented from inst_buf
// S_DRAIN | flushed while waiting; swallow the old ack, pc = flush target
module if_fetch_stage #(
  parameter logic [31:0]           RESET_PC   = 32'hBFC0_0000,
  parameter int                    EXC_CODE_W = 5,
  parameter logic [EXC_CODE_W-1:0] EC_NONE    = 5'h10,
  parameter logic [EXC_CODE_W-1:0] EC_ADEL    = 5'h04
) (
  input  logic                  cpu_clk_75M,
  input  logic                  cpu_rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [31:0]           flush_pc_i,
  input  logic                  branch_flag_i,
  input  logic [31:0]           branch_target_i,
  output logic                  inst_req,
  output logic [31:0]           inst_addr,
  input  logic                  inst_ack,
  input  logic [31:0]           inst_rdata,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic [EXC_CODE_W-1:0] exc_code_o,
  output logic [31:0]           exc_badvaddr_o,
  output logic                  stallreq_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        pend_valid;
  logic [31:0] inst_buf;
  logic [31:0] drain_addr;

  logic        aligned;
  logic        fetch_done;
  logic        ack_taken;
  logic        advance;
  logic [31:0] next_pc;

  // Only stall[0] concerns the fetch stage.
  logic        unused_stall;
  assign unused_stall = ^stall[5:1];

  assign aligned = (pc[1:0] == 2'b00);
  assign if_pc   = pc;

  // Memory port and IF/ID presentation, decoded from the current state.
  always_comb begin
    inst_req       = 1'b0;
    inst_addr      = pc;
    if_inst        = 32'h0;
    exc_code_o     = EC_NONE;
    exc_badvaddr_o = 32'h0;
    stallreq_if    = 1'b0;
    fetch_done     = 1'b0;
    ack_taken      = 1'b0;
    case (state)
      S_REQ: begin
        if (aligned) begin
          inst_req = 1'b1;
          if (inst_ack) begin
            if_inst    = inst_rdata;
            fetch_done = 1'b1;
            ack_taken  = 1'b1;
          end else begin
            stallreq_if = 1'b1;
          end
        end else begin
          // Misaligned pc never reaches memory; it completes at once as AdEL.
          exc_code_o     = EC_ADEL;
          exc_badvaddr_o = pc;
          fetch_done     = 1'b1;
        end
      end
      S_WAIT: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          if_inst    = inst_rdata;
          fetch_done = 1'b1;
          ack_taken  = 1'b1;
        end else begin
          stallreq_if = 1'b1;
        end
      end
      S_HOLD: begin
        if_inst    = inst_buf;
        fetch_done = 1'b1;
      end
      S_DRAIN: begin
        // Keep the stale request alive so memory sees a stable address until it answers.
        inst_req    = 1'b1;
        inst_addr   = drain_addr;
        stallreq_if = ~inst_ack;
      end
      default: begin
        inst_req = 1'b0;
      end
    endcase
    if (flush) begin
      if_inst        = 32'h0;
      exc_code_o     = EC_NONE;
      exc_badvaddr_o = 32'h0;
    end
  end

  assign advance = fetch_done & ~stall[0];

  // Next sequential pc: a live branch wins over a remembered one.
  always_comb begin
    if (branch_flag_i)   next_pc = branch_target_i;
    else if (pend_valid) next_pc = pend_target;
    else                 next_pc = pc + 32'd4;
  end

  // PC, pending-branch and fetch state machine.
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      inst_buf    <= 32'h0;
      drain_addr  <= 32'h0;
    end else if (flush) begin
      pc         <= flush_pc_i;
      pend_valid <= 1'b0;
      if (state == S_WAIT && !inst_ack) begin
        state      <= S_DRAIN;
        drain_addr <= pc;
      end else begin
        state <= S_REQ;
      end
    end else begin
      if (advance) begin
        pc <= next_pc;
        if (!branch_flag_i && pend_valid) pend_valid <= 1'b0;
      end else if (branch_flag_i) begin
        // The in-flight pc is the delay slot; remember the target for later.
        pend_valid  <= 1'b1;
        pend_target <= branch_target_i;
      end
      case (state)
        S_REQ, S_WAIT: begin
          if (!fetch_done) begin
            state <= S_WAIT;
          end else if (stall[0] && aligned) begin
            inst_buf <= inst_rdata;
            state    <= S_HOLD;
          end else begin
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (!stall[0]) state <= S_REQ;
        end
        S_DRAIN: begin
          if (inst_ack) state <= S_REQ;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Fetch and wait-cycle counters; both wrap naturally at 2^32.
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_wait_cnt  <= 32'h0;
    end else begin
      if (ack_taken && !flush) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stallreq_if)         perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`else
  logic unused_ack_taken;
  assign unused_ack_taken = ack_taken;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed plan steps followed by randomized traffic,
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0]  EC_NONE  = 5'h10;
  localparam logic [4:0]  EC_ADEL  = 5'h04;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_badvaddr_o;
  logic        stallreq_if;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  if_fetch_stage dut (
    .cpu_clk_75M     (cpu_clk_75M),
    .cpu_rst         (cpu_rst),
    .stall           (stall),
    .flush           (flush),
    .flush_pc_i      (flush_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_ack        (inst_ack),
    .inst_rdata      (inst_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .exc_code_o      (exc_code_o),
    .exc_badvaddr_o  (exc_badvaddr_o),
    .stallreq_if     (stallreq_if)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_wait_cnt   (perf_wait_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what the stage owes the pipeline, not how it is built.
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_t;
  logic        m_held;       // a fetched word is parked waiting for stall release
  logic [31:0] m_buf;
  logic        m_waiting;    // a request was issued on an earlier cycle, no answer yet
  logic        m_drain;      // a flushed request still owes an answer
  logic [31:0] m_drain_addr;
  int unsigned m_fetches;
  int unsigned m_waits;

  // Outputs seen in the most recent step, for the directed plan checks.
  logic        s_req, s_sr;
  logic [31:0] s_addr, s_inst, s_pc, s_badv;
  logic [4:0]  s_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pend_v = 0; m_pend_t = 0; m_held = 0; m_buf = 0;
    m_waiting = 0; m_drain = 0; m_drain_addr = 0; m_fetches = 0; m_waits = 0;
  endtask

  task automatic do_reset();
    cpu_rst = 1; stall = 0; flush = 0; flush_pc_i = 0; branch_flag_i = 0;
    branch_target_i = 0; inst_ack = 0; inst_rdata = 0;
    repeat (2) @(posedge cpu_clk_75M);
    #1;
    cpu_rst = 0;
    model_reset();
  endtask

  // One clock: drive inputs, check outputs against the model, clock, advance the model.
  task automatic step(input logic ack, input logic [31:0] rd, input logic st0,
                      input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] fpc);
    logic        e_req, e_sr, al, fetched, adv;
    logic [31:0] e_addr, e_inst, e_badv;
    logic [4:0]  e_exc;
    logic [4:0]  st_hi;
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetches);
    chk("perf_wait_cnt", perf_wait_cnt, m_waits);
`endif
    st_hi = 5'($urandom);
    stall = {st_hi, st0}; inst_ack = ack; inst_rdata = rd;
    branch_flag_i = br; branch_target_i = bt; flush = fl; flush_pc_i = fpc;
    #1;
    al = (m_pc[1:0] == 2'b00);
    e_req = 0; e_addr = m_pc; e_inst = 0; e_sr = 0; e_exc = EC_NONE; e_badv = 0;
    if (m_drain) begin
      e_req = 1; e_addr = m_drain_addr; e_sr = !ack;
    end else if (m_held) begin
      e_inst = m_buf;
    end else if (!al) begin
      e_exc = EC_ADEL; e_badv = m_pc;
    end else begin
      e_req = 1; e_inst = ack ? rd : 32'h0; e_sr = !ack;
    end
    if (fl) begin
      e_inst = 0; e_exc = EC_NONE; e_badv = 0;
    end
    s_req = inst_req; s_addr = inst_addr; s_inst = if_inst; s_pc = if_pc;
    s_exc = exc_code_o; s_badv = exc_badvaddr_o; s_sr = stallreq_if;
    chk("inst_req", 32'(inst_req), 32'(e_req));
    if (e_req) chk("inst_addr", inst_addr, e_addr);
    chk("if_pc", if_pc, m_pc);
    chk("if_inst", if_inst, e_inst);
    chk("exc_code_o", 32'(exc_code_o), 32'(e_exc));
    chk("exc_badvaddr_o", exc_badvaddr_o, e_badv);
    chk("stallreq_if", 32'(stallreq_if), 32'(e_sr));

    if (!fl && !m_drain && !m_held && al && ack) m_fetches++;
    if (e_sr) m_waits++;
    if (fl) begin
      m_drain      = m_waiting && !ack;
      m_drain_addr = m_pc;
      m_pc = fpc; m_pend_v = 0; m_held = 0; m_waiting = 0;
    end else begin
      fetched = !m_drain && (m_held || !al || ack);
      adv     = fetched && !st0;
      if (adv) begin
        if (br) m_pc = bt;
        else if (m_pend_v) begin m_pc = m_pend_t; m_pend_v = 0; end
        else m_pc = m_pc + 32'd4;
      end else if (br) begin
        m_pend_v = 1; m_pend_t = bt;
      end
      if (m_drain) begin
        if (ack) m_drain = 0;
      end else if (adv) begin
        m_held = 0; m_waiting = 0;
      end else if (fetched) begin
        if (!m_held && al) begin m_held = 1; m_buf = rd; end
        m_waiting = 0;
      end else begin
        m_waiting = 1;
      end
    end
    @(posedge cpu_clk_75M);
    #1;
  endtask

  initial begin
    logic        r_ack, r_st0, r_br, r_fl;
    logic [31:0] r_rd, r_bt, r_fpc;

    // Reset state.
    do_reset();
    chk("rst_inst_req", 32'(inst_req), 32'h1);
    chk("rst_inst_addr", inst_addr, RESET_PC);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_exc", 32'(exc_code_o), 32'(EC_NONE));
    chk("rst_badv", exc_badvaddr_o, 32'h0);
    chk("rst_stallreq", 32'(stallreq_if), 32'h1);

    // Same-cycle ack, no stall: back-to-back sequential fetches.
    step(1, 32'h1111_0000, 0, 0, 0, 0, 0);
    chk("seq_addr0", s_addr, 32'hBFC0_0000);
    chk("seq_sr0", 32'(s_sr), 32'h0);
    step(1, 32'h1111_0004, 0, 0, 0, 0, 0);
    chk("seq_addr1", s_addr, 32'hBFC0_0004);
    step(1, 32'h1111_0008, 0, 0, 0, 0, 0);
    chk("seq_addr2", s_addr, 32'hBFC0_0008);
    chk("seq_sr2", 32'(s_sr), 32'h0);

    // Ack delayed three cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 0, 0, 0, 0, 0);
      chk("wait_addr", s_addr, 32'hBFC0_0000);
      chk("wait_sr", 32'(s_sr), 32'h1);
    end
    step(1, 32'h1234_5678, 0, 0, 0, 0, 0);
    chk("wait_inst", s_inst, 32'h1234_5678);
    chk("wait_sr_ack", 32'(s_sr), 32'h0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("wait_next_addr", s_addr, 32'hBFC0_0004);

    // Branch while stalled on the delay slot: target taken from the pending latch.
    do_reset();
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'hAAAA_5555, 1, 1, 32'h8000_1000, 0, 0);
    chk("br_slot_addr", s_addr, 32'hBFC0_0004);
    step(0, 32'h0, 1, 0, 0, 0, 0);
    chk("br_hold_inst", s_inst, 32'hAAAA_5555);
    chk("br_hold_req", 32'(s_req), 32'h0);
    step(0, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("br_target_addr", s_addr, 32'h8000_1000);

    // Flush while waiting: old request drained, data dropped.
    do_reset();
    step(0, 32'h0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 1, 32'hBFC0_0380);
    chk("fl_addr0", s_addr, 32'hBFC0_0000);
    chk("fl_inst0", s_inst, 32'h0);
    step(0, 32'h0, 0, 0, 0, 0, 0);
    chk("drain_addr", s_addr, 32'hBFC0_0000);
    chk("drain_req", 32'(s_req), 32'h1);
    step(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("drain_inst", s_inst, 32'h0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("fl_new_addr", s_addr, 32'hBFC0_0380);

    // Flush to a misaligned pc: AdEL, then pc+4.
    step(1, 32'h0, 0, 0, 0, 1, 32'h8000_0002);
    step(1, 32'h5, 0, 0, 0, 0, 0);
    chk("adel_req", 32'(s_req), 32'h0);
    chk("adel_exc", 32'(s_exc), 32'h04);
    chk("adel_badv", s_badv, 32'h8000_0002);
    chk("adel_inst", s_inst, 32'h0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("adel_next_pc", s_pc, 32'h8000_0006);
    step(1, 32'h0, 0, 0, 0, 1, 32'h8000_0000);

`ifdef IF_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 32'h0, 0, 0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0);
      step(1, 32'(i), 0, 0, 0, 0, 0);
    end
    chk("perf_fetch_10", perf_fetch_cnt, 32'd10);
    chk("perf_wait_20", perf_wait_cnt, 32'd20);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_ack = ($urandom_range(0, 9) < 6);
      r_rd  = $urandom;
      r_st0 = ($urandom_range(0, 9) < 2);
      r_br  = ($urandom_range(0, 9) == 0);
      r_bt  = $urandom & 32'hFFFF_FFFC;
      r_fl  = ($urandom_range(0, 19) == 0);
      r_fpc = $urandom;
      if ($urandom_range(0, 3) != 0) r_fpc = r_fpc & 32'hFFFF_FFFC;
      step(r_ack, r_rd, r_st0, r_br, r_bt, r_fl, r_fpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
